// File: rtl/dec_pkg.sv
// Shared decoder definitions: cn_r_ctrl FSM states, CN record layout helpers
// and the default code geometry.
package dec_pkg;

    localparam int MSG_WIDTH   = 8;
    localparam int COL_CNT_WID = 5;
    localparam int N_COL       = 24;
    localparam int ROW_WID     = 4;
    localparam int N_ROW       = 12;
    localparam int ITER_WID    = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_LOAD     = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_ITER_END = 3'd4,
        ST_DONE     = 3'd5
    } cn_r_state_e;

    typedef enum logic [2:0] {
        FLD_SGN_VEC  = 3'd0,
        FLD_SIGN_TOT = 3'd1,
        FLD_IDX0     = 3'd2,
        FLD_MIN1     = 3'd3,
        FLD_MIN0     = 3'd4
    } cn_field_e;

    // The record is packed MSB-first as {min0, min1, idx0, sign_tot, sgn_vec}.
    function automatic int cn_rec_width(input int msg_w, input int col_w, input int n_col);
        return 32'sd2 * (msg_w - 32'sd1) + col_w + 32'sd1 + n_col;
    endfunction

    function automatic int cn_fld_lsb(input cn_field_e fld, input int msg_w,
                                      input int col_w, input int n_col);
        int lsb;
        case (fld)
            FLD_SGN_VEC:  lsb = 32'sd0;
            FLD_SIGN_TOT: lsb = n_col;
            FLD_IDX0:     lsb = n_col + 32'sd1;
            FLD_MIN1:     lsb = n_col + 32'sd1 + col_w;
            FLD_MIN0:     lsb = n_col + 32'sd1 + col_w + msg_w - 32'sd1;
            default:      lsb = 32'sd0;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/cn_r_ctrl_rec.sv
// Row-record capture for cn_r: latches the CN record on LOAD and presents the
// sign bit of the edge the controller will show next.
module cn_rec_reg #(
    parameter int MSG_WIDTH   = dec_pkg::MSG_WIDTH,
    parameter int COL_CNT_WID = dec_pkg::COL_CNT_WID,
    parameter int N_COL       = dec_pkg::N_COL,
    parameter int REC_WID     = dec_pkg::cn_rec_width(MSG_WIDTH, COL_CNT_WID, N_COL)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [REC_WID-1:0]     i_rec,
    input  logic [COL_CNT_WID-1:0] i_col_nxt,
    output logic [MSG_WIDTH-2:0]   o_min0,
    output logic [MSG_WIDTH-2:0]   o_min1,
    output logic [COL_CNT_WID-1:0] o_idx0,
    output logic                   o_sign_tot,
    output logic                   o_sign
);
    import dec_pkg::*;

    localparam int SEL_WID  = 32'sd1 <<< COL_CNT_WID;
    localparam int LSB_SGN  = cn_fld_lsb(FLD_SGN_VEC,  MSG_WIDTH, COL_CNT_WID, N_COL);
    localparam int LSB_STOT = cn_fld_lsb(FLD_SIGN_TOT, MSG_WIDTH, COL_CNT_WID, N_COL);
    localparam int LSB_IDX0 = cn_fld_lsb(FLD_IDX0,     MSG_WIDTH, COL_CNT_WID, N_COL);
    localparam int LSB_MIN1 = cn_fld_lsb(FLD_MIN1,     MSG_WIDTH, COL_CNT_WID, N_COL);
    localparam int LSB_MIN0 = cn_fld_lsb(FLD_MIN0,     MSG_WIDTH, COL_CNT_WID, N_COL);

    logic [MSG_WIDTH-2:0]   min0_r;
    logic [MSG_WIDTH-2:0]   min1_r;
    logic [COL_CNT_WID-1:0] idx0_r;
    logic                   sign_tot_r;
    logic                   sign_r;
    logic [N_COL-1:0]       sgn_vec_r;
    logic [N_COL-1:0]       sgn_src_s;
    logic [SEL_WID-1:0]     sgn_pad_s;

    // Sign source: the incoming vector on the load edge, so edge 0 is ready on the first issue cycle.
    always_comb begin
        sgn_src_s = sgn_vec_r;
        if (i_load) begin
            sgn_src_s = i_rec[LSB_SGN +: N_COL];
        end else begin
            sgn_src_s = sgn_vec_r;
        end
        sgn_pad_s = '0;
        sgn_pad_s[N_COL-1:0] = sgn_src_s;
    end

    // Record capture and registered per-edge sign select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min0_r     <= '0;
            min1_r     <= '0;
            idx0_r     <= '0;
            sign_tot_r <= 1'b0;
            sgn_vec_r  <= '0;
            sign_r     <= 1'b0;
        end else begin
            if (i_load) begin
                min0_r     <= i_rec[LSB_MIN0 +: MSG_WIDTH-1];
                min1_r     <= i_rec[LSB_MIN1 +: MSG_WIDTH-1];
                idx0_r     <= i_rec[LSB_IDX0 +: COL_CNT_WID];
                sign_tot_r <= i_rec[LSB_STOT];
                sgn_vec_r  <= i_rec[LSB_SGN +: N_COL];
            end
            sign_r <= sgn_pad_s[i_col_nxt];
        end
    end

    assign o_min0     = min0_r;
    assign o_min1     = min1_r;
    assign o_idx0     = idx0_r;
    assign o_sign_tot = sign_tot_r;
    assign o_sign     = sign_r;

endmodule

// File: rtl/cn_r_ctrl.sv
// CN-recover sequencer: walks every row once per iteration, loads the CN record
// and steps the edge counter so cn_r emits one c2v message per accepted cycle.
module cn_r_ctrl #(
    parameter int MSG_WIDTH   = dec_pkg::MSG_WIDTH,
    parameter int COL_CNT_WID = dec_pkg::COL_CNT_WID,
    parameter int N_COL       = dec_pkg::N_COL,
    parameter int ROW_WID     = dec_pkg::ROW_WID,
    parameter int N_ROW       = dec_pkg::N_ROW,
    parameter int ITER_WID    = dec_pkg::ITER_WID
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic                                           i_start,
    input  logic [ITER_WID-1:0]                            i_max_iter,
    input  logic                                           i_early_stop,
    output logic                                           o_busy,
    output logic                                           o_done,
    output logic [ITER_WID-1:0]                            o_iter_cnt,
    output logic                                           o_cn_rd_en,
    output logic [ROW_WID-1:0]                             o_cn_rd_addr,
    input  logic [2*(MSG_WIDTH-1)+COL_CNT_WID+1+N_COL-1:0] i_cn_rd_data,
    output logic [MSG_WIDTH-2:0]                           o_v2c_abs_0,
    output logic [MSG_WIDTH-2:0]                           o_v2c_abs_1,
    output logic [COL_CNT_WID-1:0]                         o_idx_0,
    output logic                                           o_v2c_sign,
    output logic                                           o_v2c_sign_tot,
    output logic [COL_CNT_WID-1:0]                         o_col_cnt,
    output logic                                           o_is_first_iter,
    output logic                                           o_cn_r_vld,
    input  logic                                           i_ds_rdy
);
    import dec_pkg::*;

    localparam int REC_WID = cn_rec_width(MSG_WIDTH, COL_CNT_WID, N_COL);
    localparam logic [COL_CNT_WID-1:0] COL_LAST = COL_CNT_WID'(N_COL - 32'sd1);
    localparam logic [ROW_WID-1:0]     ROW_LAST = ROW_WID'(N_ROW - 32'sd1);

    cn_r_state_e           state_r;
    cn_r_state_e           state_nxt_s;
    logic [ROW_WID-1:0]    row_r;
    logic [ROW_WID-1:0]    row_nxt_s;
    logic [COL_CNT_WID-1:0] col_r;
    logic [COL_CNT_WID-1:0] col_nxt_s;
    logic [ITER_WID-1:0]   iter_r;
    logic [ITER_WID-1:0]   iter_nxt_s;
    logic [ITER_WID-1:0]   iter_inc_s;
    logic [ITER_WID-1:0]   limit_r;
    logic [ITER_WID-1:0]   limit_nxt_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_en_r;
    logic                  vld_r;
    logic                  first_r;
    logic                  busy_nxt_s;
    logic                  accept_s;
    logic                  stop_s;
    logic                  load_s;

    assign accept_s   = vld_r & i_ds_rdy;
    assign iter_inc_s = iter_r + ITER_WID'(1'b1);
    assign stop_s     = i_early_stop | (iter_inc_s == limit_r);
    assign load_s     = (state_r == ST_LOAD);

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        iter_nxt_s  = iter_r;
        limit_nxt_s = limit_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_RD;
                    row_nxt_s   = '0;
                    col_nxt_s   = '0;
                    iter_nxt_s  = '0;
                    limit_nxt_s = (i_max_iter == '0) ? ITER_WID'(1'b1) : i_max_iter;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_LOAD;
            end
            ST_LOAD: begin
                col_nxt_s   = '0;
                state_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    if (col_r == COL_LAST) begin
                        col_nxt_s = '0;
                        if (row_r == ROW_LAST) begin
                            state_nxt_s = ST_ITER_END;
                        end else begin
                            row_nxt_s   = row_r + ROW_WID'(1'b1);
                            state_nxt_s = ST_RD;
                        end
                    end else begin
                        col_nxt_s = col_r + COL_CNT_WID'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ITER_END: begin
                iter_nxt_s = iter_inc_s;
                if (stop_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    row_nxt_s   = '0;
                    state_nxt_s = ST_RD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s inside {ST_RD, ST_LOAD, ST_ISSUE, ST_ITER_END});
    end

    // State, counters and output strobes, all registered from the next-state view.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            row_r   <= '0;
            col_r   <= '0;
            iter_r  <= '0;
            limit_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
            vld_r   <= 1'b0;
            first_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            iter_r  <= iter_nxt_s;
            limit_r <= limit_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            rd_en_r <= (state_nxt_s == ST_RD);
            vld_r   <= (state_nxt_s == ST_ISSUE);
            first_r <= busy_nxt_s & (iter_nxt_s == '0);
        end
    end

    cn_rec_reg #(
        .MSG_WIDTH   (MSG_WIDTH),
        .COL_CNT_WID (COL_CNT_WID),
        .N_COL       (N_COL),
        .REC_WID     (REC_WID)
    ) u_rec (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load_s),
        .i_rec      (i_cn_rd_data),
        .i_col_nxt  (col_nxt_s),
        .o_min0     (o_v2c_abs_0),
        .o_min1     (o_v2c_abs_1),
        .o_idx0     (o_idx_0),
        .o_sign_tot (o_v2c_sign_tot),
        .o_sign     (o_v2c_sign)
    );

    assign o_busy          = busy_r;
    assign o_done          = done_r;
    assign o_iter_cnt      = iter_r;
    assign o_cn_rd_en      = rd_en_r;
    assign o_cn_rd_addr    = row_r;
    assign o_col_cnt       = col_r;
    assign o_is_first_iter = first_r;
    assign o_cn_r_vld      = vld_r;

endmodule

// File: tb/tb_cn_r_ctrl.sv
// Directed bench for cn_r_ctrl: a position-based reference model checked every
// cycle, plus hand-computed literals for latency, counts and record fields.
`timescale 1ns/1ps
module tb_cn_r_ctrl;

    localparam int MW       = 8;
    localparam int CW       = 5;
    localparam int NC       = 24;
    localparam int RW       = 4;
    localparam int NR       = 12;
    localparam int IW       = 5;
    localparam int REC_W    = 2*(MW-1) + CW + 1 + NC;
    localparam int ROW_CYC  = NC + 2;
    localparam int ITER_CYC = NR*ROW_CYC + 1;

    typedef struct packed {
        logic [MW-2:0] m0;
        logic [MW-2:0] m1;
        logic [CW-1:0] ix;
        logic          st;
        logic [NC-1:0] sv;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             early = 1'b0;
    logic             rdy = 1'b1;
    logic [IW-1:0]    max_iter = '0;
    logic [REC_W-1:0] rd_data = '0;

    logic             busy, done, rd_en, sign, stot, first, vld;
    logic [IW-1:0]    iter_cnt;
    logic [RW-1:0]    rd_addr;
    logic [MW-2:0]    abs0, abs1;
    logic [CW-1:0]    idx0, col;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // model state
    bit m_run = 1'b0;
    bit m_done_now = 1'b0;
    int m_pos = 0;
    int m_it = 0;
    int m_limit = 1;
    int t_start = 0;
    int t_done = 0;
    bit seen_done = 1'b0;

    // statistics and snapshots read back by the directed checks
    int vld_cnt, first_vld_cnt, acc_cnt, col10_cnt;
    logic [7:0] s3_abs0, s3_abs1, s3_idx, s3_sign, s4_sign, s4_stot;

    cn_r_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_max_iter      (max_iter),
        .i_early_stop    (early),
        .o_busy          (busy),
        .o_done          (done),
        .o_iter_cnt      (iter_cnt),
        .o_cn_rd_en      (rd_en),
        .o_cn_rd_addr    (rd_addr),
        .i_cn_rd_data    (rd_data),
        .o_v2c_abs_0     (abs0),
        .o_v2c_abs_1     (abs1),
        .o_idx_0         (idx0),
        .o_v2c_sign      (sign),
        .o_v2c_sign_tot  (stot),
        .o_col_cnt       (col),
        .o_is_first_iter (first),
        .o_cn_r_vld      (vld),
        .i_ds_rdy        (rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t rec(input int r);
        rec_t x;
        if (r == 0) begin
            x.m0 = 7'd5; x.m1 = 7'd9; x.ix = 5'd3; x.st = 1'b1; x.sv = 24'h000008;
        end else begin
            x.m0 = 7'(5 + 3*r);
            x.m1 = 7'(40 + r);
            x.ix = 5'((3 + 7*r) % NC);
            x.st = ((r % 2) == 1);
            x.sv = 24'(32'h00C3A5 ^ (32'h005A5A5 >> r) ^ (32'd1 << (r + 11)));
        end
        return x;
    endfunction

    // CN memory: one-cycle read latency, garbage on cycles without a read
    always @(posedge clk) begin
        if (rd_en) rd_data <= rec(int'(rd_addr));
        else       rd_data <= REC_W'({$urandom(), $urandom()});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle compare against the reference model
    initial begin
        int   row;
        int   p;
        int   e_col;
        int   e_addr;
        bit   e_busy, e_done, e_rd, e_vld, e_first;
        rec_t rr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {busy, done, iter_cnt, rd_en, rd_addr, abs0, abs1,
                                      idx0, sign, stot, col, first, vld}, 64'd0);
                m_run = 1'b0; m_done_now = 1'b0; m_it = 0; m_pos = 0;
            end else begin
                e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_vld = 1'b0; e_first = 1'b0;
                e_col = 0; e_addr = 0; row = 0; p = 0;
                if (m_done_now) begin
                    e_done = 1'b1;
                end else if (m_run) begin
                    e_busy  = 1'b1;
                    e_first = (m_it == 0);
                    if (m_pos != ITER_CYC - 1) begin
                        row = m_pos / ROW_CYC;
                        p   = m_pos % ROW_CYC;
                        if (p == 0) begin
                            e_rd = 1'b1; e_addr = row;
                        end else if (p >= 2) begin
                            e_vld = 1'b1; e_col = p - 2;
                        end
                    end
                end
                chk("ctrl{busy,done,rd,vld,first}", {busy, done, rd_en, vld, first},
                    {e_busy, e_done, e_rd, e_vld, e_first});
                chk("iter_cnt", iter_cnt, m_it);
                if (e_rd) chk("rd_addr", rd_addr, e_addr);
                if (e_vld) begin
                    rr = rec(row);
                    chk("col_cnt", col, e_col);
                    chk("abs0", abs0, rr.m0);
                    chk("abs1", abs1, rr.m1);
                    chk("idx0", idx0, rr.ix);
                    chk("sign_tot", stot, rr.st);
                    chk("sign", sign, rr.sv[e_col]);
                    if (m_it == 0 && row == 0 && e_col == 3) begin
                        s3_abs0 = 8'(abs0); s3_abs1 = 8'(abs1); s3_idx = 8'(idx0); s3_sign = 8'(sign);
                    end
                    if (m_it == 0 && row == 0 && e_col == 4) begin
                        s4_sign = 8'(sign); s4_stot = 8'(stot);
                    end
                end
                if (vld) vld_cnt++;
                if (vld && first) first_vld_cnt++;
                if (vld && col == 5'd10) col10_cnt++;
                if (vld && rdy) begin
                    chk("edge_order", col, acc_cnt % NC);
                    acc_cnt++;
                end
                if (done) begin
                    seen_done = 1'b1; t_done = cyc;
                end
                // advance the model by one cycle
                if (m_done_now) begin
                    m_done_now = 1'b0;
                end else if (m_run) begin
                    if (e_vld && !rdy) begin
                        m_pos = m_pos;
                    end else if (m_pos == ITER_CYC - 1) begin
                        m_it++;
                        if (early || m_it == m_limit) begin
                            m_run = 1'b0; m_done_now = 1'b1;
                        end else begin
                            m_pos = 0;
                        end
                    end else begin
                        m_pos++;
                    end
                end else if (start) begin
                    m_run = 1'b1; m_pos = 0; m_it = 0;
                    m_limit = (max_iter == '0) ? 1 : int'(max_iter);
                    t_start = cyc;
                end
            end
        end
    end

    task automatic clear_stats();
        vld_cnt = 0; first_vld_cnt = 0; acc_cnt = 0; col10_cnt = 0; seen_done = 1'b0;
        s3_abs0 = 8'hFF; s3_abs1 = 8'hFF; s3_idx = 8'hFF; s3_sign = 8'hFF;
        s4_sign = 8'hFF; s4_stot = 8'hFF;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!seen_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, seen_done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // two full iterations, no stall; stray start and max_iter change mid-run
        max_iter = 5'd2; early = 1'b0; rdy = 1'b1;
        clear_stats();
        pulse_start();
        repeat (50) @(posedge clk);
        #1 start = 1'b1; max_iter = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2000, "t1_done_seen");
        chk("t1_vld_cycles", vld_cnt, 576);
        chk("t1_first_vld", first_vld_cnt, 288);
        chk("t1_done_latency", t_done - t_start, 627);   // RD at T+1, 2*313 cycles, DONE one later
        chk("t1_iter_cnt", iter_cnt, 2);
        chk("t1_col3_abs0", s3_abs0, 5);
        chk("t1_col3_abs1", s3_abs1, 9);
        chk("t1_col3_idx0", s3_idx, 3);
        chk("t1_col3_sign", s3_sign, 1);
        chk("t1_col4_sign", s4_sign, 0);
        chk("t1_col4_sign_tot", s4_stot, 1);

        // max_iter=0 runs one iteration; start raised only in the DONE cycle is ignored
        max_iter = 5'd0;
        clear_stats();
        pulse_start();
        repeat (313) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(10, "t2_done_seen");
        chk("t2_done_latency", t_done - t_start, 314);
        chk("t2_iter_cnt", iter_cnt, 1);
        chk("t2_vld_cycles", vld_cnt, 288);
        repeat (5) @(posedge clk);
        #1 chk("t2_start_in_done_ignored", busy, 1'b0);

        // 4-cycle stall at row 0 col 10, then random back-pressure
        max_iter = 5'd1;
        clear_stats();
        pulse_start();
        repeat (12) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1 rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("t3_col10_hold", col10_cnt, 5);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 rdy = ($urandom_range(0, 3) != 0);
        end
        rdy = 1'b1;
        wait_done(3000, "t3_done_seen");
        chk("t3_accepted_edges", acc_cnt, 288);
        chk("t3_iter_cnt", iter_cnt, 1);

        // early stop at the first ITER_END
        max_iter = 5'd16; early = 1'b1;
        clear_stats();
        pulse_start();
        wait_done(1000, "t4_done_seen");
        chk("t4_iter_cnt", iter_cnt, 1);
        chk("t4_done_latency", t_done - t_start, 314);
        early = 1'b0;

        // asynchronous reset at row 5 col 7, then a clean restart
        max_iter = 5'd3;
        clear_stats();
        pulse_start();
        repeat (139) @(posedge clk);
        #1 chk("t5_pre_reset_col", {vld, col}, {1'b1, 5'd7});
        rst_n = 1'b0;
        #1 chk("t5_async_zero", {busy, done, iter_cnt, rd_en, rd_addr, abs0, abs1,
                                 idx0, sign, stot, col, first, vld}, 64'd0);
        seen_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("t5_no_done_after_reset", seen_done, 1'b0);
        max_iter = 5'd1;
        clear_stats();
        pulse_start();
        wait_done(1000, "t5_restart_done_seen");
        chk("t5_restart_iter_cnt", iter_cnt, 1);
        chk("t5_restart_edges", acc_cnt, 288);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
